// File: rtl/keyboard_matrix_reader.sv
`default_nettype none
// ============================================================================
//  Module      : keyboard_matrix_reader
//  Description : Turns PS/2 set-2 scancode bytes into an active-low MSX key
//                matrix. The byte stream is decoded as follows:
//                  - E0 and F0 prefixes are tracked.
//                  - An E1 prefix starts a Pause sequence, and the bytes
//                    that follow it are swallowed.
//                  - {ext,code} is looked up in the keyboard map RAM.
//                  - The addressed matrix bit is then set or cleared.
//                Rows are read back through a registered row select port.
//  Revision    : 1.0 - initial release
// ============================================================================
module keyboard_matrix_reader #(
   parameter int ROWS    = 11,
   parameter int E1_SKIP = 7
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       code_valid,
   input  logic [7:0] code_byte,
   output logic       code_ready,
   input  logic       clear_keys,
   output logic [8:0] ram_address,
   output logic       ram_wren,
   input  logic [7:0] ram_q,
   input  logic [3:0] row_sel,
   output logic [7:0] row_data,
   output logic       key_event
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_APPLY = 2'd2;

   localparam int         SKIP_W   = $clog2(E1_SKIP + 1);
   localparam logic [4:0] C_ROWS   = 5'(ROWS);

   localparam logic [7:0] BYTE_E0  = 8'hE0;
   localparam logic [7:0] BYTE_E1  = 8'hE1;
   localparam logic [7:0] BYTE_F0  = 8'hF0;

   logic [1:0]            state_q, state_d;
   logic [ROWS-1:0][7:0]  matrix_q, matrix_d;
   logic [SKIP_W-1:0]     skip_q, skip_d;
   logic                  ext_q, ext_d;
   logic                  brk_q, brk_d;
   logic                  op_brk_q, op_brk_d;
   logic [8:0]            ram_address_q, ram_address_d;
   logic [7:0]            row_data_q, row_data_d;
   logic                  key_event_q, key_event_d;

   logic                  accept;
   logic                  is_prefix;
   logic                  entry_ok;
   logic [3:0]            entry_row;
   logic [2:0]            entry_col;
   logic                  unused_ram_bit;

   // Map entry decode: bit 3 of the entry carries no meaning for the matrix
   assign entry_row      = ram_q[7:4];
   assign entry_col      = ram_q[2:0];
   assign unused_ram_bit = ram_q[3];
   assign entry_ok       = (ram_q != 8'hFF) && ({1'b0, entry_row} < C_ROWS);

   assign accept    = code_valid && code_ready;
   assign is_prefix = (code_byte == BYTE_E0) || (code_byte == BYTE_E1) ||
                      (code_byte == BYTE_F0);

   assign ram_address = ram_address_q;
   assign ram_wren    = 1'b0;
   assign row_data    = row_data_q;
   assign key_event   = key_event_q;

   // FSM state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: a lookup starts only for a non-prefix byte outside a Pause skip
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept && (skip_q == '0) && !is_prefix) state_d = ST_WAIT;
         ST_WAIT:  state_d = ST_APPLY;
         ST_APPLY: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      if (clear_keys) state_d = ST_IDLE;
   end

   // FSM outputs
   always_comb begin
      code_ready = (state_q == ST_IDLE);
   end

   // Datapath next values: prefix tracking, lookup launch, matrix update
   always_comb begin
      skip_d        = skip_q;
      ext_d         = ext_q;
      brk_d         = brk_q;
      op_brk_d      = op_brk_q;
      ram_address_d = ram_address_q;
      matrix_d      = matrix_q;
      key_event_d   = 1'b0;

      if (accept) begin
         if (skip_q != '0) begin
            skip_d = skip_q - 1'b1;
         end else if (code_byte == BYTE_E1) begin
            skip_d = SKIP_W'(E1_SKIP);
            ext_d  = 1'b0;
            brk_d  = 1'b0;
         end else if (code_byte == BYTE_E0) begin
            ext_d = 1'b1;
         end else if (code_byte == BYTE_F0) begin
            brk_d = 1'b1;
         end else begin
            ram_address_d = {ext_q, code_byte};
            op_brk_d      = brk_q;
            ext_d         = 1'b0;
            brk_d         = 1'b0;
         end
      end

      // Only a real change of the bit produces an event (repeats are silent)
      if ((state_q == ST_APPLY) && entry_ok) begin
         if (matrix_q[entry_row][entry_col] != op_brk_q) begin
            matrix_d[entry_row][entry_col] = op_brk_q;
            key_event_d                    = 1'b1;
         end
      end

      // Clear overrides any same-cycle update and drops all prefix state
      if (clear_keys) begin
         matrix_d    = '1;
         skip_d      = '0;
         ext_d       = 1'b0;
         brk_d       = 1'b0;
         key_event_d = 1'b0;
      end

      row_data_d = ({1'b0, row_sel} < C_ROWS) ? matrix_q[row_sel] : 8'hFF;
   end

   // Datapath registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         matrix_q      <= '1;
         skip_q        <= '0;
         ext_q         <= 1'b0;
         brk_q         <= 1'b0;
         op_brk_q      <= 1'b0;
         ram_address_q <= '0;
         row_data_q    <= 8'hFF;
         key_event_q   <= 1'b0;
      end else begin
         matrix_q      <= matrix_d;
         skip_q        <= skip_d;
         ext_q         <= ext_d;
         brk_q         <= brk_d;
         op_brk_q      <= op_brk_d;
         ram_address_q <= ram_address_d;
         row_data_q    <= row_data_d;
         key_event_q   <= key_event_d;
      end
   end

endmodule
`default_nettype wire
